mem_store_ctrl: RTL

Store-side memory controller, the write-path counterpart of the load extractor in the core's memory stage. Accepts one store request (SW/SH/SB) with byte address and register data. Steers the data onto the correct byte lanes, generates byte enables and checks alignment. Runs the memory write handshake, or a read-modify-write sequence when the memory has no byte enables.

---
 rtl/mem_store_ctrl_pkg.sv | 37 +++
 rtl/mem_store_ctrl_if.sv | 35 +++
 rtl/mem_store_ctrl_align.sv | 49 ++++
 rtl/mem_store_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/mem_store_ctrl_pkg.sv
// Shared definitions for the store-side memory controller: opcode constants,
// store-type codes, the controller state enum and the store-type decoder.
package mem_pkg;

   localparam logic [5:0] OPCSB    = 6'h28;
   localparam logic [5:0] OPCSH    = 6'h29;
   localparam logic [5:0] OPCSW    = 6'h2B;
   localparam logic [5:0] OPCDUMMY = 6'h3F;

   localparam logic [1:0] STORE_TYPE_NONE = 2'd0;
   localparam logic [1:0] STORE_TYPE_SB   = 2'd1;
   localparam logic [1:0] STORE_TYPE_SH   = 2'd2;
   localparam logic [1:0] STORE_TYPE_SW   = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_WRITE = 3'd2,
      S_DONE  = 3'd3,
      S_EXC   = 3'd4
   } state_e;

   // OPCDUMMY defers to the store type resolved by pipeline control.
   function automatic logic [1:0] decode_store_type(input logic [5:0] opcode,
                                                    input logic [1:0] type_f);
      logic [1:0] st;
      case (opcode)
         OPCSW:    st = STORE_TYPE_SW;
         OPCSH:    st = STORE_TYPE_SH;
         OPCSB:    st = STORE_TYPE_SB;
         OPCDUMMY: st = type_f;
         default:  st = STORE_TYPE_NONE;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/mem_store_ctrl_if.sv
// Request and memory-bus signals of the store controller. Handshake: a request is
// taken when iStart is high in IDLE; a memory strobe stays high until iMemAck.
interface mem_store_if;
   import mem_pkg::*;

   logic        iStart;
   logic [5:0]  iOpcode;
   logic [1:0]  iStoreTypeF;
   logic [31:0] iAddress;
   logic [31:0] iData;
   logic        oBusy;
   logic        oDone;
   logic        oException;
   logic [31:0] oMemAddr;
   logic [31:0] oMemWData;
   logic [3:0]  oMemByteEn;
   logic        oMemWrite;
   logic        oMemRead;
   logic [31:0] iMemRData;
   logic        iMemAck;
   state_e      oDbgState;

   modport slave (
      input  iStart, iOpcode, iStoreTypeF, iAddress, iData, iMemRData, iMemAck,
      output oBusy, oDone, oException, oMemAddr, oMemWData, oMemByteEn,
             oMemWrite, oMemRead, oDbgState
   );

   modport master (
      output iStart, iOpcode, iStoreTypeF, iAddress, iData, iMemRData, iMemAck,
      input  oBusy, oDone, oException, oMemAddr, oMemWData, oMemByteEn,
             oMemWrite, oMemRead, oDbgState
   );

endinterface

// File: rtl/mem_store_ctrl_align.sv
// store_align: combinational lane steering, byte-enable generation, alignment
// check and read-modify-write byte merge for 32-bit stores.
module store_align
   import mem_pkg::*;
(
   input  logic [1:0]  store_type_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] data_i,
   output logic [31:0] wdata_o,
   output logic [3:0]  ben_o,
   output logic        misalign_o,
   input  logic [31:0] old_i,
   input  logic [31:0] new_i,
   input  logic [3:0]  merge_ben_i,
   output logic [31:0] merged_o
);

   always_comb begin
      wdata_o    = '0;
      ben_o      = '0;
      misalign_o = 1'b0;
      case (store_type_i)
         STORE_TYPE_SB: begin
            wdata_o = {4{data_i[7:0]}};
            ben_o   = 4'b0001 << addr_lo_i;
         end
         STORE_TYPE_SH: begin
            wdata_o    = {2{data_i[15:0]}};
            ben_o      = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            misalign_o = addr_lo_i[0];
         end
         STORE_TYPE_SW: begin
            wdata_o    = data_i;
            ben_o      = 4'b1111;
            misalign_o = |addr_lo_i;
         end
         default: ;
      endcase
   end

   // Enabled lanes take the new store data, the rest keep the word read back.
   always_comb begin
      merged_o = old_i;
      for (int b = 0; b < 4; b++) begin
         if (merge_ben_i[b]) merged_o[8*b +: 8] = new_i[8*b +: 8];
      end
   end

endmodule

// File: rtl/mem_store_ctrl.sv
// Store-side memory controller: SW/SH/SB write path with alignment exceptions.
// Define MEMSTORE_RMW_EN to build the READ->WRITE merge for memories without byte enables.
module mem_store_ctrl
   import mem_pkg::*;
(
   input  logic      iCLK,
   input  logic      iRST_n,
   mem_store_if.slave bus
);

   state_e      state_q, state_d;
   logic [29:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  ben_q, ben_d;
   logic        write_q, write_d;
   logic        read_q, read_d;
   logic        done_q, done_d;
   logic        exc_q, exc_d;
   logic        busy_q, busy_d;

   logic [1:0]  req_type;
   logic [31:0] al_wdata;
   logic [3:0]  al_ben;
   logic        al_misalign;
   logic [31:0] rmw_merged;

   assign req_type = decode_store_type(bus.iOpcode, bus.iStoreTypeF);

   store_align u_align (
      .store_type_i (req_type),
      .addr_lo_i    (bus.iAddress[1:0]),
      .data_i       (bus.iData),
      .wdata_o      (al_wdata),
      .ben_o        (al_ben),
      .misalign_o   (al_misalign),
      .old_i        (bus.iMemRData),
      .new_i        (wdata_q),
      .merge_ben_i  (ben_q),
      .merged_o     (rmw_merged)
   );

`ifndef MEMSTORE_RMW_EN
   logic unused_rmw;
   assign unused_rmw = ^{rmw_merged, read_q};
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      ben_d   = ben_q;
      write_d = 1'b0;
      read_d  = 1'b0;
      done_d  = 1'b0;
      exc_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.iStart) begin
               addr_d  = bus.iAddress[31:2];
               wdata_d = al_wdata;
               ben_d   = al_ben;
               if (al_misalign) begin
                  state_d = S_EXC;
                  done_d  = 1'b1;
                  exc_d   = 1'b1;
               end else if (req_type == STORE_TYPE_NONE) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
`ifdef MEMSTORE_RMW_EN
               end else if (req_type != STORE_TYPE_SW) begin
                  state_d = S_READ;
                  read_d  = 1'b1;
`endif
               end else begin
                  state_d = S_WRITE;
                  write_d = 1'b1;
               end
            end
         end
`ifdef MEMSTORE_RMW_EN
         S_READ: begin
            if (bus.iMemAck) begin
               // The merged word is written whole, so every lane is enabled.
               wdata_d = rmw_merged;
               ben_d   = 4'b1111;
               write_d = 1'b1;
               state_d = S_WRITE;
            end else begin
               read_d = 1'b1;
            end
         end
`endif
         S_WRITE: begin
            if (bus.iMemAck) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               write_d = 1'b1;
            end
         end
         S_DONE, S_EXC: state_d = S_IDLE;
         default:       state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         ben_q   <= '0;
         write_q <= 1'b0;
         read_q  <= 1'b0;
         done_q  <= 1'b0;
         exc_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ben_q   <= ben_d;
         write_q <= write_d;
         read_q  <= read_d;
         done_q  <= done_d;
         exc_q   <= exc_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.oBusy      = busy_q;
   assign bus.oDone      = done_q;
   assign bus.oException = exc_q;
   assign bus.oMemAddr   = {addr_q, 2'b00};
   assign bus.oMemWData  = wdata_q;
   assign bus.oMemByteEn = ben_q;
   assign bus.oMemWrite  = write_q;
`ifdef MEMSTORE_RMW_EN
   assign bus.oMemRead   = read_q;
`else
   assign bus.oMemRead   = 1'b0;
`endif
   assign bus.oDbgState  = state_q;

endmodule
